// File: rtl/cache_wb_param.sv
// Direct-mapped write-back / write-allocate cache with a single-word memory port.
// FLUSH writes back every dirty line and leaves it valid and clean.
module cache_wb_param #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned NUM_LINES      = 16,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  proc_req_valid,
    output logic                  proc_req_ready,
    input  logic [1:0]            proc_req_op,
    input  logic [ADDR_WIDTH-1:0] proc_req_addr,
    input  logic [DATA_WIDTH-1:0] proc_req_data,
    output logic                  proc_resp_valid,
    input  logic                  proc_resp_ready,
    output logic [DATA_WIDTH-1:0] proc_resp_data,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_we,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_data
);
    localparam int unsigned OFF_W     = $clog2(WORDS_PER_LINE);
    localparam int unsigned IDX_W     = $clog2(NUM_LINES);
    localparam int unsigned TAG_W     = ADDR_WIDTH - 2 - OFF_W - IDX_W;
    localparam int unsigned LOC_W     = IDX_W + OFF_W;
    localparam int unsigned NUM_WORDS = NUM_LINES * WORDS_PER_LINE;

    localparam logic [1:0] OP_NONE  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd2;
    localparam logic [1:0] OP_FLUSH = 2'd3;

    typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, REFILL, FLUSH, RESP} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              op_q;
    logic [ADDR_WIDTH-3:0]   addr_q;
    logic [DATA_WIDTH-1:0]   req_data_q;
    logic [NUM_LINES-1:0]    valid_q, valid_d, dirty_q, dirty_d;
    logic [OFF_W-1:0]        wcnt_q, wcnt_d, wcnt_inc;
    logic [IDX_W-1:0]        lcnt_q, lcnt_d, lcnt_inc;
    logic                    wait_q, wait_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

    logic [TAG_W-1:0]        tag_q [NUM_LINES];
    logic [DATA_WIDTH-1:0]   line_data [NUM_WORDS];

    logic                    req_ready_d, resp_valid_d, mem_valid_d, mem_we_d;
    logic [DATA_WIDTH-1:0]   resp_data_d, mem_wdata_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_d;
    logic                    arr_we, tag_we;
    logic [LOC_W-1:0]        arr_loc;
    logic [DATA_WIDTH-1:0]   arr_wdata;

    logic [OFF_W-1:0]        req_off;
    logic [IDX_W-1:0]        req_idx, wb_line;
    logic [TAG_W-1:0]        req_tag;
    logic                    hit, accept, mem_hs, resp_hs, last_word, last_line, flush_dirty;
    logic                    unused_addr_lsb;

    assign unused_addr_lsb = ^proc_req_addr[1:0];

    assign req_off     = addr_q[0 +: OFF_W];
    assign req_idx     = addr_q[OFF_W +: IDX_W];
    assign req_tag     = addr_q[ADDR_WIDTH-3 -: TAG_W];
    assign hit         = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign accept      = proc_req_valid && proc_req_ready && (proc_req_op != OP_NONE);
    assign mem_hs      = mem_req_valid && mem_req_ready;
    assign resp_hs     = proc_resp_valid && proc_resp_ready;
    assign wcnt_inc    = OFF_W'(wcnt_q + 1'b1);
    assign lcnt_inc    = IDX_W'(lcnt_q + 1'b1);
    assign last_word   = (wcnt_q == OFF_W'(WORDS_PER_LINE - 1));
    assign last_line   = (lcnt_q == IDX_W'(NUM_LINES - 1));
    assign flush_dirty = valid_q[lcnt_q] && dirty_q[lcnt_q];
    // Line being written back: the miss victim, or the line under the flush scan
    assign wb_line     = (state_q == FLUSH) ? lcnt_q : req_idx;

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            op_q            <= '0;
            addr_q          <= '0;
            req_data_q      <= '0;
            valid_q         <= '0;
            dirty_q         <= '0;
            wcnt_q          <= '0;
            lcnt_q          <= '0;
            wait_q          <= 1'b0;
            rdata_q         <= '0;
            proc_req_ready  <= 1'b0;
            proc_resp_valid <= 1'b0;
            proc_resp_data  <= '0;
            mem_req_valid   <= 1'b0;
            mem_req_we      <= 1'b0;
            mem_req_addr    <= '0;
            mem_req_wdata   <= '0;
        end else begin
            state_q         <= state_d;
            valid_q         <= valid_d;
            dirty_q         <= dirty_d;
            wcnt_q          <= wcnt_d;
            lcnt_q          <= lcnt_d;
            wait_q          <= wait_d;
            rdata_q         <= rdata_d;
            proc_req_ready  <= req_ready_d;
            proc_resp_valid <= resp_valid_d;
            proc_resp_data  <= resp_data_d;
            mem_req_valid   <= mem_valid_d;
            mem_req_we      <= mem_we_d;
            mem_req_addr    <= mem_addr_d;
            mem_req_wdata   <= mem_wdata_d;
            if (accept) begin
                op_q       <= proc_req_op;
                addr_q     <= proc_req_addr[ADDR_WIDTH-1:2];
                req_data_q <= proc_req_data;
            end
        end
    end

    // Tag and data storage carry no reset; valid bits guard them
    always_ff @(posedge clk) begin
        if (arr_we) line_data[arr_loc] <= arr_wdata;
        if (tag_we) tag_q[req_idx] <= req_tag;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (accept) state_d = (proc_req_op == OP_FLUSH) ? FLUSH : COMPARE;
            COMPARE: begin
                if (hit)                                        state_d = RESP;
                else if (valid_q[req_idx] && dirty_q[req_idx])  state_d = WRITEBACK;
                else                                            state_d = REFILL;
            end
            WRITEBACK: if (mem_hs && last_word) state_d = REFILL;
            REFILL:    if (wait_q && mem_resp_valid && last_word) state_d = COMPARE;
            FLUSH: begin
                if ((!mem_req_valid && !flush_dirty && last_line) ||
                    (mem_hs && last_word && last_line))
                    state_d = RESP;
            end
            RESP:      if (resp_hs) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        req_ready_d  = (state_d == IDLE);
        resp_valid_d = 1'b0;
        resp_data_d  = '0;
        mem_valid_d  = mem_req_valid;
        mem_we_d     = mem_req_we;
        mem_addr_d   = mem_req_addr;
        mem_wdata_d  = mem_req_wdata;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        wcnt_d       = wcnt_q;
        lcnt_d       = lcnt_q;
        wait_d       = wait_q;
        rdata_d      = rdata_q;
        arr_we       = 1'b0;
        arr_loc      = '0;
        arr_wdata    = '0;
        tag_we       = 1'b0;
        case (state_q)
            IDLE: begin
                wcnt_d  = '0;
                lcnt_d  = '0;
                wait_d  = 1'b0;
                rdata_d = '0;
            end
            COMPARE: begin
                if (hit) begin
                    if (op_q == OP_WRITE) begin
                        arr_we           = 1'b1;
                        arr_loc          = {req_idx, req_off};
                        arr_wdata        = req_data_q;
                        dirty_d[req_idx] = 1'b1;
                        rdata_d          = '0;
                    end else begin
                        rdata_d = line_data[{req_idx, req_off}];
                    end
                end else begin
                    // The line is about to be overwritten; it is invalid until the refill completes
                    valid_d[req_idx] = 1'b0;
                    wcnt_d           = '0;
                end
            end
            WRITEBACK, FLUSH: begin
                if (!mem_req_valid) begin
                    if (state_q == WRITEBACK || flush_dirty) begin
                        mem_valid_d = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {tag_q[wb_line], wb_line, wcnt_q, 2'b00};
                        mem_wdata_d = line_data[{wb_line, wcnt_q}];
                    end else if (!last_line) begin
                        lcnt_d = lcnt_inc;
                    end
                end else if (mem_hs) begin
                    if (!last_word) begin
                        wcnt_d      = wcnt_inc;
                        mem_addr_d  = {tag_q[wb_line], wb_line, wcnt_inc, 2'b00};
                        mem_wdata_d = line_data[{wb_line, wcnt_inc}];
                    end else begin
                        mem_valid_d = 1'b0;
                        mem_we_d    = 1'b0;
                        wcnt_d      = '0;
                        if (state_q == FLUSH) begin
                            dirty_d[lcnt_q] = 1'b0;
                            if (!last_line) lcnt_d = lcnt_inc;
                        end
                    end
                end
            end
            REFILL: begin
                if (!mem_req_valid && !wait_q) begin
                    mem_valid_d = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = {req_tag, req_idx, wcnt_q, 2'b00};
                    mem_wdata_d = '0;
                end else if (mem_hs) begin
                    mem_valid_d = 1'b0;
                    wait_d      = 1'b1;
                end else if (wait_q && mem_resp_valid) begin
                    arr_we    = 1'b1;
                    arr_loc   = {req_idx, wcnt_q};
                    arr_wdata = mem_resp_data;
                    wait_d    = 1'b0;
                    if (last_word) begin
                        valid_d[req_idx] = 1'b1;
                        dirty_d[req_idx] = 1'b0;
                        tag_we           = 1'b1;
                        wcnt_d           = '0;
                    end else begin
                        wcnt_d = wcnt_inc;
                    end
                end
            end
            RESP: begin
                resp_valid_d = !resp_hs;
                resp_data_d  = resp_hs ? '0 : rdata_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_wb_param.sv
// Directed bench for cache_wb_param: cold miss, hits, dirty eviction, flush,
// response back-pressure and reset during refill, against a simple memory model.
module tb_cache_wb_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        proc_req_valid, proc_req_ready;
    logic [1:0]  proc_req_op;
    logic [31:0] proc_req_addr, proc_req_data;
    logic        proc_resp_valid, proc_resp_ready;
    logic [31:0] proc_resp_data;
    logic        mem_req_valid, mem_req_ready, mem_req_we;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_wb_param dut (
        .clk            (clk),
        .reset          (reset),
        .proc_req_valid (proc_req_valid),
        .proc_req_ready (proc_req_ready),
        .proc_req_op    (proc_req_op),
        .proc_req_addr  (proc_req_addr),
        .proc_req_data  (proc_req_data),
        .proc_resp_valid(proc_resp_valid),
        .proc_resp_ready(proc_resp_ready),
        .proc_resp_data (proc_resp_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_we     (mem_req_we),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Memory model: toggling ready, read data one cycle after the handshake
    logic        log_we[$];
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    logic [31:0] mem_store [logic [31:0]];
    logic        rd_pend;
    logic [31:0] rd_addr;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (mem_store.exists(a)) return mem_store[a];
        return a ^ 32'hA5A50000;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_resp_valid <= 1'b0;
            mem_resp_data  <= 32'h0;
            mem_req_ready  <= 1'b1;
            rd_pend        <= 1'b0;
            rd_addr        <= 32'h0;
        end else begin
            mem_req_ready  <= ~mem_req_ready;
            mem_resp_valid <= 1'b0;
            if (rd_pend) begin
                mem_resp_valid <= 1'b1;
                mem_resp_data  <= mem_val(rd_addr);
                rd_pend        <= 1'b0;
            end
            if (mem_req_valid && mem_req_ready) begin
                log_we.push_back(mem_req_we);
                log_addr.push_back(mem_req_addr);
                log_data.push_back(mem_req_wdata);
                if (mem_req_we) mem_store[mem_req_addr] = mem_req_wdata;
                else begin
                    rd_pend <= 1'b1;
                    rd_addr <= mem_req_addr;
                end
            end
        end
    end

    // A stalled memory request must not change until it is accepted
    logic        pv, pr, pwe;
    logic [31:0] pa, pd;
    always @(negedge clk) begin
        if (reset === 1'b1 && pv && !pr)
            chk("mem_req_hold", {mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata},
                {1'b1, pwe, pa, pd});
        pv  = (reset === 1'b1) && mem_req_valid;
        pr  = mem_req_ready;
        pwe = mem_req_we;
        pa  = mem_req_addr;
        pd  = mem_req_wdata;
    end

    logic        exp_we[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];

    task automatic log_clear();
        log_we.delete();
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic expect_req(input logic we, input logic [31:0] a, input logic [31:0] d);
        exp_we.push_back(we);
        exp_addr.push_back(a);
        exp_data.push_back(d);
    endtask

    task automatic cmp_log(input string tag);
        chk({tag, "_count"}, 128'(log_addr.size()), 128'(exp_addr.size()));
        for (int i = 0; i < log_addr.size() && i < exp_addr.size(); i++)
            chk(tag, {log_we[i], log_addr[i], exp_we[i] ? log_data[i] : 32'h0},
                {exp_we[i], exp_addr[i], exp_we[i] ? exp_data[i] : 32'h0});
        exp_we.delete();
        exp_addr.delete();
        exp_data.delete();
    endtask

    // One processor transaction; lat = rising edges from acceptance to proc_resp_valid
    task automatic txn(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input int hold, output logic [31:0] rd, output int lat,
                       output logic idle_ok);
        log_clear();
        @(negedge clk);
        proc_resp_ready = (hold == 0);
        proc_req_valid  = 1'b1;
        proc_req_op     = op;
        proc_req_addr   = addr;
        proc_req_data   = wd;
        @(posedge clk);
        @(negedge clk);
        proc_req_valid = 1'b0;
        proc_req_op    = 2'd0;
        lat = 0;
        while (!proc_resp_valid && lat < 3000) begin
            @(negedge clk);
            lat++;
        end
        rd = proc_resp_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("resp_stall_stable", {proc_resp_valid, proc_req_ready, proc_resp_data},
                {1'b1, 1'b0, rd});
        end
        proc_resp_ready = 1'b1;
        @(negedge clk);
        idle_ok = !proc_resp_valid && proc_req_ready;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          lat;
        logic        idle_ok;
        int          n_hs;
        int          guard;

        reset           = 1'b0;
        proc_req_valid  = 1'b0;
        proc_req_op     = 2'd0;
        proc_req_addr   = 32'h0;
        proc_req_data   = 32'h0;
        proc_resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {proc_req_ready, proc_resp_valid, proc_resp_data, mem_req_valid,
                              mem_req_we, mem_req_addr, mem_req_wdata}, 128'd0);
        reset = 1'b1;
        #1 chk("ready_before_first_edge", proc_req_ready, 1'b0);
        @(negedge clk);
        chk("ready_after_first_edge", proc_req_ready, 1'b1);

        // NONE with valid is ignored
        log_clear();
        proc_req_valid = 1'b1;
        proc_req_op    = 2'd0;
        proc_req_addr  = 32'h100;
        repeat (3) @(negedge clk);
        chk("none_ignored", {proc_req_ready, proc_resp_valid, mem_req_valid}, 3'b100);
        chk("none_no_mem", 128'(log_addr.size()), 128'd0);
        proc_req_valid = 1'b0;

        // Cold read miss
        for (int i = 0; i < 4; i++) expect_req(1'b0, 32'h100 + 32'(4 * i), 32'h0);
        txn(2'd1, 32'h100, 32'h0, 0, rd, lat, idle_ok);
        chk("cold_read_data", rd, 32'hA5A50100);
        chk("cold_read_idle", idle_ok, 1'b1);
        cmp_log("cold_read_mem");

        // Write hit then read hit
        txn(2'd2, 32'h104, 32'h2021EE83, 0, rd, lat, idle_ok);
        chk("write_hit_latency", 128'(lat), 128'd2);
        chk("write_hit_resp_data", rd, 32'h0);
        chk("write_hit_idle", idle_ok, 1'b1);
        cmp_log("write_hit_mem");
        txn(2'd1, 32'h104, 32'h0, 0, rd, lat, idle_ok);
        chk("read_hit_latency", 128'(lat), 128'd2);
        chk("read_hit_data", rd, 32'h2021EE83);
        cmp_log("read_hit_mem");

        // Conflict miss on a dirty line: write-back then refill
        for (int i = 0; i < 4; i++)
            expect_req(1'b1, 32'h100 + 32'(4 * i),
                       (i == 1) ? 32'h2021EE83 : ((32'h100 + 32'(4 * i)) ^ 32'hA5A50000));
        for (int i = 0; i < 4; i++) expect_req(1'b0, 32'h200 + 32'(4 * i), 32'h0);
        txn(2'd1, 32'h204, 32'h0, 0, rd, lat, idle_ok);
        chk("evict_read_data", rd, 32'hA5A50204);
        cmp_log("evict_mem");

        // Dirty line 0 (hit) and line 5 (write-allocate miss)
        txn(2'd2, 32'h200, 32'h11110000, 0, rd, lat, idle_ok);
        chk("dirty0_latency", 128'(lat), 128'd2);
        cmp_log("dirty0_mem");
        for (int i = 0; i < 4; i++) expect_req(1'b0, 32'h50 + 32'(4 * i), 32'h0);
        txn(2'd2, 32'h54, 32'h55550054, 0, rd, lat, idle_ok);
        chk("dirty5_resp_data", rd, 32'h0);
        cmp_log("dirty5_mem");

        // Flush writes back lines 0 and 5 only
        for (int i = 0; i < 4; i++)
            expect_req(1'b1, 32'h200 + 32'(4 * i),
                       (i == 0) ? 32'h11110000 : ((32'h200 + 32'(4 * i)) ^ 32'hA5A50000));
        for (int i = 0; i < 4; i++)
            expect_req(1'b1, 32'h50 + 32'(4 * i),
                       (i == 1) ? 32'h55550054 : ((32'h50 + 32'(4 * i)) ^ 32'hA5A50000));
        txn(2'd3, 32'h0, 32'h0, 0, rd, lat, idle_ok);
        chk("flush_resp_data", rd, 32'h0);
        chk("flush_idle", idle_ok, 1'b1);
        cmp_log("flush_mem");
        txn(2'd3, 32'h0, 32'h0, 0, rd, lat, idle_ok);
        chk("flush2_responded", 128'(lat < 3000), 128'd1);
        cmp_log("flush2_mem");

        // Flushed line stays valid; response held under back-pressure
        txn(2'd1, 32'h54, 32'h0, 3, rd, lat, idle_ok);
        chk("stall_latency", 128'(lat), 128'd2);
        chk("stall_data", rd, 32'h55550054);
        chk("stall_idle", idle_ok, 1'b1);
        cmp_log("stall_mem");

        // Reset after the second refill read handshake
        log_clear();
        @(negedge clk);
        proc_req_valid = 1'b1;
        proc_req_op    = 2'd1;
        proc_req_addr  = 32'h300;
        @(posedge clk);
        @(negedge clk);
        proc_req_valid = 1'b0;
        proc_req_op    = 2'd0;
        n_hs  = 0;
        guard = 0;
        while (guard < 200) begin
            @(negedge clk);
            guard++;
            if (mem_req_valid && mem_req_ready) begin
                n_hs++;
                if (n_hs == 2) break;
            end
        end
        chk("abort_second_read_seen", 128'(n_hs), 128'd2);
        @(posedge clk);
        #1 reset = 1'b0;
        #1 chk("abort_async_outputs", {proc_req_ready, proc_resp_valid, proc_resp_data, mem_req_valid,
                                        mem_req_we, mem_req_addr, mem_req_wdata}, 128'd0);
        repeat (2) @(negedge clk);
        chk("abort_mem_count", 128'(log_addr.size()), 128'd2);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_ready_after_release", proc_req_ready, 1'b1);
        for (int i = 0; i < 4; i++) expect_req(1'b0, 32'h300 + 32'(4 * i), 32'h0);
        txn(2'd1, 32'h300, 32'h0, 0, rd, lat, idle_ok);
        chk("abort_reread_data", rd, 32'hA5A50300);
        cmp_log("abort_reread_mem");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
